// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter for the single CPU memory port.
// One outstanding transaction, attributes registered at grant, watchdog abort on missing ack.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [1:0]            grant,
  output logic                  busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                state, state_nxt;
  logic                  last_grant, last_grant_nxt;
  logic [TW-1:0]         timer, timer_nxt;
  logic                  mem_req_nxt, mem_we_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_wdata_nxt;
  logic [1:0]            grant_nxt;
  logic                  m0_ack_nxt, m0_err_nxt, m1_ack_nxt, m1_err_nxt;
  logic [DATA_WIDTH-1:0] m0_rdata_nxt, m1_rdata_nxt;
  logic                  pick1;

  assign busy = (state != IDLE);

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  assign pick1 = m1_req && (!m0_req || !last_grant);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    timer_nxt      = timer;
    mem_req_nxt    = mem_req;
    mem_we_nxt     = mem_we;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    grant_nxt      = grant;
    m0_ack_nxt     = 1'b0;
    m0_err_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m1_err_nxt     = 1'b0;
    m0_rdata_nxt   = m0_rdata;
    m1_rdata_nxt   = m1_rdata;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          mem_req_nxt    = 1'b1;
          mem_we_nxt     = pick1 ? m1_we    : m0_we;
          mem_addr_nxt   = pick1 ? m1_addr  : m0_addr;
          mem_wdata_nxt  = pick1 ? m1_wdata : m0_wdata;
          grant_nxt      = pick1 ? 2'b10 : 2'b01;
          last_grant_nxt = pick1;
          timer_nxt      = '0;
          state_nxt      = BUSY;
        end
      end
      BUSY: begin
        if (timer != T_MAX) timer_nxt = timer + 1'b1;
        // An ack arriving on the watchdog's last cycle still completes normally.
        if (mem_ack) begin
          if (grant[0]) begin
            m0_ack_nxt = 1'b1;
            if (!mem_we) m0_rdata_nxt = mem_rdata;
          end else begin
            m1_ack_nxt = 1'b1;
            if (!mem_we) m1_rdata_nxt = mem_rdata;
          end
          mem_req_nxt = 1'b0;
          state_nxt   = RELEASE;
        end else if (timer == T_LAST) begin
          m0_err_nxt  = grant[0];
          m1_err_nxt  = grant[1];
          mem_req_nxt = 1'b0;
          state_nxt   = RELEASE;
        end
      end
      RELEASE: begin
        // Wait out the ack that trails the final mem_req cycle.
        if (!mem_ack) begin
          grant_nxt = 2'b00;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      timer      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant      <= 2'b00;
      m0_ack     <= 1'b0;
      m0_err     <= 1'b0;
      m1_ack     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      timer      <= timer_nxt;
      mem_req    <= mem_req_nxt;
      mem_we     <= mem_we_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      grant      <= grant_nxt;
      m0_ack     <= m0_ack_nxt;
      m0_err     <= m0_err_nxt;
      m1_ack     <= m1_ack_nxt;
      m1_err     <= m1_err_nxt;
      m0_rdata   <= m0_rdata_nxt;
      m1_rdata   <= m1_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a small ack<=req memory model.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          m0_req, m0_we, m0_ack, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_ack, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    grant;
  logic          busy;
  logic          ack_en;
  logic [DW-1:0] mem [16];

  int n_chk = 0;
  int n_err = 0;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack follows req by one cycle (gated by ack_en); contents preset while in reset.
  always @(posedge clk) begin
    mem_ack   <= mem_req & ack_en;
    mem_rdata <= mem[mem_addr[5:2]];
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= {16'hC0DE, 16'(i)};
      mem[2] <= 32'hDEADBEEF;
    end else if (mem_req && mem_we) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int port);
    int n = 0;
    while (((port == 0) ? m0_ack : m1_ack) !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("ack_seen", (port == 0) ? m0_ack : m1_ack, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    chk("idle_seen", busy, 0);
  endtask

  initial begin
    int total, c0, c1;
    logic [1:0] exp_g;
    rst_n = 1'b0; ack_en = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4;  m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h24; m1_wdata = '0;

    // Reset with both requests pending.
    tick(); tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;
    tick();
    chk("first_grant", grant, 2'b01);
    chk("first_addr", mem_addr, 32'h4);
    m1_req = 1'b0;
    wait_ack(0);
    m0_req = 1'b0;
    wait_idle();

    // Single read with cycle-exact latency.
    m0_req = 1'b1; m0_addr = 32'h8;
    tick();
    chk("rd_mem_req_c1", mem_req, 1);
    chk("rd_grant_c1", grant, 2'b01);
    chk("rd_addr_c1", mem_addr, 32'h8);
    tick();
    chk("rd_ack_c2", m0_ack, 0);
    tick();
    chk("rd_ack_c3", m0_ack, 1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_mem_req_c3", mem_req, 0);
    m0_req = 1'b0;
    tick();
    chk("rd_ack_c4", m0_ack, 0);
    chk("rd_grant_c4", grant, 2'b01);
    tick();
    chk("rd_grant_c5", grant, 2'b00);
    chk("rd_busy_c5", busy, 0);

    // Contention after reset: strict alternation starting with port 0.
    rst_n = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h20;
    m1_req = 1'b1; m1_addr = 32'h24;
    tick();
    rst_n = 1'b1;
    total = 0; c0 = 0; c1 = 0;
    for (int cyc = 0; cyc < 200 && total < 8; cyc++) begin
      tick();
      if (m0_ack || m1_ack || m0_err || m1_err) begin
        exp_g = (total % 2 == 0) ? 2'b01 : 2'b10;
        chk("rr_grant", grant, exp_g);
        chk("rr_ack_port", {m1_ack, m0_ack}, exp_g);
        chk("rr_no_err", {m1_err, m0_err}, 0);
        if (m0_ack) begin
          chk("rr_m0_rdata", m0_rdata, 32'hC0DE0008);
          c0++;
          if (c0 == 4) m0_req = 1'b0;
        end
        if (m1_ack) begin
          chk("rr_m1_rdata", m1_rdata, 32'hC0DE0009);
          c1++;
          if (c1 == 4) m1_req = 1'b0;
        end
        total++;
      end
    end
    chk("rr_total", total, 8);
    chk("rr_m0_count", c0, 4);
    wait_idle();

    // Port 1 write; its read-data register must keep the previous read.
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h10; m1_wdata = 32'h12345678;
    tick();
    chk("wr_grant", grant, 2'b10);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_wdata", mem_wdata, 32'h12345678);
    wait_ack(1);
    chk("wr_m1_rdata_held", m1_rdata, 32'hC0DE0009);
    chk("wr_mem_word4", mem[4], 32'h12345678);
    m1_req = 1'b0; m1_we = 1'b0;
    wait_idle();

    // Watchdog: memory silent, error 8 cycles after BUSY entry.
    ack_en = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h0;
    tick();
    chk("to_busy", busy, 1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk("to_no_err_early", m0_err, 0);
    end
    tick();
    chk("to_err", m0_err, 1);
    chk("to_no_ack", m0_ack, 0);
    chk("to_mem_req", mem_req, 0);
    m0_req = 1'b0;
    tick();
    chk("to_err_pulse", m0_err, 0);
    chk("to_grant_idle", grant, 0);
    chk("to_busy_idle", busy, 0);
    ack_en = 1'b1;
    m1_req = 1'b1; m1_addr = 32'h28;
    tick();
    chk("to_next_grant", grant, 2'b10);
    wait_ack(1);
    chk("to_next_rdata", m1_rdata, 32'hC0DE000A);
    m1_req = 1'b0;
    wait_idle();

    // Reset during BUSY of a port-0 transaction.
    ack_en = 1'b0;
    m0_req = 1'b1; m0_addr = 32'h8;
    tick();
    chk("mr_grant", grant, 2'b01);
    tick();
    rst_n = 1'b0;
    m1_req = 1'b1; m1_addr = 32'h24;
    tick();
    chk("mr_mem_req", mem_req, 0);
    chk("mr_grant_clr", grant, 0);
    chk("mr_busy", busy, 0);
    chk("mr_no_pulse", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    tick();
    chk("mr_no_pulse2", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    ack_en = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("mr_m0_priority", grant, 2'b01);
    wait_ack(0);
    chk("mr_m0_rdata", m0_rdata, 32'hDEADBEEF);
    m0_req = 1'b0;
    wait_ack(1);
    chk("mr_m1_grant", grant, 2'b10);
    m1_req = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
